// File: rtl/instr_mem_bridge.sv
// instr_mem_bridge: connects an instruction-fetch request/grant port to a
// single-ported instruction SRAM. Requests are held for a configurable
// minimum number of cycles, then granted when the SRAM arbiter allows it.
// Addresses outside the SRAM window are granted immediately once eligible
// and answered with a bus error instead of an SRAM access. One response is
// returned the cycle after each grant, and a new grant may issue in that
// same cycle.
module instr_mem_bridge #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned MEM_WORDS   = 16384,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         instr_req,
    input  logic [31:0]                  instr_addr,
    output logic                         instr_gnt,
    output logic [31:0]                  instr_rdata,
    output logic                         instr_err,
    output logic                         instr_valid,
    output logic                         mem_ce,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    input  logic [31:0]                  mem_rdata,
    input  logic                         mem_busy
);

    localparam int unsigned AW         = $clog2(MEM_WORDS);
    localparam logic [2:0]  WAIT_LIMIT = 3'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_wait_cnt;
    logic [2:0]  w_wait_cnt_next;
    logic        r_rsp_pend;
    logic        r_rsp_err;
    logic        w_in_range;
    logic        w_eligible;
    logic        w_gnt;

    // Window check done in 33 bits so a window ending at 4 GiB does not wrap.
    function automatic logic addr_in_window(input logic [31:0] addr);
        logic [32:0] a_ext;
        logic [32:0] lo_ext;
        logic [32:0] hi_ext;
        a_ext  = {1'b0, addr};
        lo_ext = {1'b0, ADDR_BASE};
        hi_ext = lo_ext + (33'(MEM_WORDS) << 2'd2);
        return (a_ext >= lo_ext) && (a_ext < hi_ext);
    endfunction

    assign w_in_range = addr_in_window(instr_addr);

    // Byte offset into the window, byte lanes dropped, truncated to SRAM depth.
    assign mem_addr = AW'((instr_addr - ADDR_BASE) >> 3'd2);

    // Grant decision: hold time served, then SRAM free or no SRAM needed.
    always_comb begin
        w_eligible = 1'b0;
        w_gnt      = 1'b0;
        if (reset_n && instr_req && (r_wait_cnt == WAIT_LIMIT)) begin
            w_eligible = 1'b1;
        end else begin
            w_eligible = 1'b0;
        end
        if (w_eligible && (!w_in_range || !mem_busy)) begin
            w_gnt = 1'b1;
        end else begin
            w_gnt = 1'b0;
        end
    end

    // Hold counter and request-tracking state transitions.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        if (!instr_req || w_gnt) begin
            w_wait_cnt_next = 3'd0;
        end else if (r_wait_cnt != WAIT_LIMIT) begin
            w_wait_cnt_next = r_wait_cnt + 3'd1;
        end else begin
            w_wait_cnt_next = r_wait_cnt;
        end
        case (r_state)
            ST_IDLE: begin
                if (instr_req && !w_gnt) begin
                    w_state_next = ST_WAIT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!instr_req || w_gnt) begin
                    w_state_next = ST_IDLE;
                end else if (w_wait_cnt_next == WAIT_LIMIT) begin
                    w_state_next = ST_GRANT;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_GRANT: begin
                if (!instr_req || w_gnt) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_GRANT;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and hold-counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 3'd0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // One response slot: set by each grant, retired the following cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_pend <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_rsp_pend <= w_gnt;
            r_rsp_err  <= w_gnt & ~w_in_range;
        end
    end

    assign instr_gnt   = w_gnt;
    assign mem_ce      = w_gnt & w_in_range;
    assign instr_valid = r_rsp_pend;
    assign instr_err   = r_rsp_pend & r_rsp_err;
    assign instr_rdata = (r_rsp_pend && !r_rsp_err) ? mem_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_instr_mem_bridge.sv
// Bench for instr_mem_bridge: three instances (no wait / 3-cycle wait /
// small offset window), directed scenarios plus a randomized run checked
// against a cycle-level reference model.
module tb_instr_mem_bridge;

    localparam logic [31:0] BASE  [3] = '{32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
    localparam int          WORDS [3] = '{16384, 16384, 16};
    localparam int          WAITS [3] = '{0, 3, 0};

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req   [3];
    logic [31:0] addr  [3];
    logic        busy  [3];
    logic [31:0] mrd   [3];
    logic        gnt   [3];
    logic        valid [3];
    logic        err   [3];
    logic        ce    [3];
    logic [31:0] rdata [3];
    logic [13:0] maddr0;
    logic [13:0] maddr1;
    logic [3:0]  maddr2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_mem_bridge #(.ADDR_BASE(32'h0000_0000), .MEM_WORDS(16384), .WAIT_CYCLES(0)) u_d0 (
        .clk(clk), .reset_n(reset_n), .instr_req(req[0]), .instr_addr(addr[0]),
        .instr_gnt(gnt[0]), .instr_rdata(rdata[0]), .instr_err(err[0]), .instr_valid(valid[0]),
        .mem_ce(ce[0]), .mem_addr(maddr0), .mem_rdata(mrd[0]), .mem_busy(busy[0]));

    instr_mem_bridge #(.ADDR_BASE(32'h0000_0000), .MEM_WORDS(16384), .WAIT_CYCLES(3)) u_d3 (
        .clk(clk), .reset_n(reset_n), .instr_req(req[1]), .instr_addr(addr[1]),
        .instr_gnt(gnt[1]), .instr_rdata(rdata[1]), .instr_err(err[1]), .instr_valid(valid[1]),
        .mem_ce(ce[1]), .mem_addr(maddr1), .mem_rdata(mrd[1]), .mem_busy(busy[1]));

    instr_mem_bridge #(.ADDR_BASE(32'h8000_0000), .MEM_WORDS(16), .WAIT_CYCLES(0)) u_db (
        .clk(clk), .reset_n(reset_n), .instr_req(req[2]), .instr_addr(addr[2]),
        .instr_gnt(gnt[2]), .instr_rdata(rdata[2]), .instr_err(err[2]), .instr_valid(valid[2]),
        .mem_ce(ce[2]), .mem_addr(maddr2), .mem_rdata(mrd[2]), .mem_busy(busy[2]));

    // SRAM content as a function of word index.
    function automatic logic [31:0] sram_word(input logic [31:0] idx);
        return (idx * 32'h9E37_79B1) + 32'h1234_5678;
    endfunction

    function automatic logic [31:0] get_maddr(input int k);
        case (k)
            0:       return {18'd0, maddr0};
            1:       return {18'd0, maddr1};
            default: return {28'd0, maddr2};
        endcase
    endfunction

    // SRAM models: data one cycle after a read enable, garbage otherwise.
    always @(posedge clk) begin
        mrd[0] <= ce[0] ? sram_word({18'd0, maddr0}) : $urandom();
        mrd[1] <= ce[1] ? sram_word({18'd0, maddr1}) : $urandom();
        mrd[2] <= ce[2] ? sram_word({28'd0, maddr2}) : $urandom();
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            req[k]  = 1'b0;
            busy[k] = 1'b0;
            addr[k] = BASE[k];
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b1; busy[k] = 1'b0; addr[k] = BASE[k] + 32'h10;
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if ({gnt[k], ce[k], valid[k], err[k]} !== 4'b0000) begin
                    n_err++; $display("FAIL reset_ctl[%0d]: got %b want 0000", k, {gnt[k], ce[k], valid[k], err[k]});
                end
                n_vec++;
                if (rdata[k] !== 32'h0) begin
                    n_err++; $display("FAIL reset_rdata[%0d]: got %h want 0", k, rdata[k]);
                end
            end
            next_cycle();
        end
        idle_all();
        reset_n = 1'b1;
        next_cycle();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (valid[k] !== 1'b0) begin
                n_err++; $display("FAIL reset_release_valid[%0d]: got %b want 0", k, valid[k]);
            end
        end
        next_cycle();
    endtask

    task automatic test_basic();
        req[0] = 1'b1; addr[0] = 32'h10;
        @(negedge clk);
        n_vec++;
        if ({gnt[0], ce[0]} !== 2'b11 || maddr0 !== 14'd4) begin
            n_err++; $display("FAIL basic_gnt: got gnt/ce %b addr %0d want 11 addr 4", {gnt[0], ce[0]}, maddr0);
        end
        next_cycle();
        req[0] = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({valid[0], err[0]} !== 2'b10 || rdata[0] !== sram_word(32'd4)) begin
            n_err++; $display("FAIL basic_rsp: got v/e %b data %h want 10 data %h", {valid[0], err[0]}, rdata[0], sram_word(32'd4));
        end
        next_cycle();
        @(negedge clk);
        n_vec++;
        if (valid[0] !== 1'b0 || rdata[0] !== 32'h0) begin
            n_err++; $display("FAIL basic_idle: got valid %b data %h want 0 0", valid[0], rdata[0]);
        end
        next_cycle();
    endtask

    task automatic test_wait();
        req[1] = 1'b1; addr[1] = 32'h20;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_vec++;
            if ({gnt[1], ce[1]} !== {(c == 3), (c == 3)}) begin
                n_err++; $display("FAIL wait_gnt_c%0d: got %b want %b", c, {gnt[1], ce[1]}, {(c == 3), (c == 3)});
            end
            next_cycle();
        end
        req[1] = 1'b0;
        @(negedge clk);
        n_vec++;
        if (valid[1] !== 1'b1 || rdata[1] !== sram_word(32'd8)) begin
            n_err++; $display("FAIL wait_rsp: got valid %b data %h want 1 %h", valid[1], rdata[1], sram_word(32'd8));
        end
        next_cycle();
        // request abandoned at cycle 2
        req[1] = 1'b1; addr[1] = 32'h40;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) req[1] = 1'b0;
            @(negedge clk);
            n_vec++;
            if ({gnt[1], valid[1]} !== 2'b00) begin
                n_err++; $display("FAIL abort_c%0d: got gnt/valid %b want 00", c, {gnt[1], valid[1]});
            end
            next_cycle();
        end
        // a new request must serve the full hold again
        req[1] = 1'b1;
        @(negedge clk);
        n_vec++;
        if (gnt[1] !== 1'b0) begin
            n_err++; $display("FAIL abort_restart: got gnt %b want 0", gnt[1]);
        end
        next_cycle();
        req[1] = 1'b0;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        req[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) addr[0] = 32'(4 * i);
            else req[0] = 1'b0;
            @(negedge clk);
            n_vec++;
            if ({gnt[0], ce[0], valid[0]} !== {(i < 3), (i < 3), (i > 0 && i < 4)}) begin
                n_err++; $display("FAIL b2b_ctl_c%0d: got %b want %b", i, {gnt[0], ce[0], valid[0]}, {(i < 3), (i < 3), (i > 0 && i < 4)});
            end
            if (i > 0 && i < 4) begin
                n_vec++;
                if (rdata[0] !== sram_word(32'(i - 1))) begin
                    n_err++; $display("FAIL b2b_data_c%0d: got %h want %h", i, rdata[0], sram_word(32'(i - 1)));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_out_of_range();
        req[2] = 1'b1; addr[2] = 32'h8000_0040;
        @(negedge clk);
        n_vec++;
        if ({gnt[2], ce[2]} !== 2'b10) begin
            n_err++; $display("FAIL oor_gnt: got gnt/ce %b want 10", {gnt[2], ce[2]});
        end
        next_cycle();
        addr[2] = 32'h8000_003C;
        @(negedge clk);
        n_vec++;
        if ({valid[2], err[2]} !== 2'b11 || rdata[2] !== 32'h0) begin
            n_err++; $display("FAIL oor_rsp: got v/e %b data %h want 11 0", {valid[2], err[2]}, rdata[2]);
        end
        n_vec++;
        if ({gnt[2], ce[2]} !== 2'b11 || maddr2 !== 4'd15) begin
            n_err++; $display("FAIL top_word_gnt: got %b addr %0d want 11 addr 15", {gnt[2], ce[2]}, maddr2);
        end
        next_cycle();
        addr[2] = 32'h7FFF_FFFC;
        @(negedge clk);
        n_vec++;
        if ({valid[2], err[2]} !== 2'b10 || rdata[2] !== sram_word(32'd15)) begin
            n_err++; $display("FAIL top_word_rsp: got v/e %b data %h want 10 %h", {valid[2], err[2]}, rdata[2], sram_word(32'd15));
        end
        n_vec++;
        if ({gnt[2], ce[2]} !== 2'b10) begin
            n_err++; $display("FAIL below_base_gnt: got %b want 10", {gnt[2], ce[2]});
        end
        next_cycle();
        req[2] = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({valid[2], err[2]} !== 2'b11) begin
            n_err++; $display("FAIL below_base_rsp: got v/e %b want 11", {valid[2], err[2]});
        end
        next_cycle();
    endtask

    task automatic test_busy();
        req[0] = 1'b1; addr[0] = 32'h100; busy[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) busy[0] = 1'b0;
            if (c == 3) req[0] = 1'b0;
            @(negedge clk);
            n_vec++;
            if ({gnt[0], ce[0], valid[0]} !== {(c == 2), (c == 2), (c == 3)}) begin
                n_err++; $display("FAIL busy_c%0d: got %b want %b", c, {gnt[0], ce[0], valid[0]}, {(c == 2), (c == 2), (c == 3)});
            end
            if (c == 3) begin
                n_vec++;
                if (rdata[0] !== sram_word(32'h40)) begin
                    n_err++; $display("FAIL busy_data: got %h want %h", rdata[0], sram_word(32'h40));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_drop();
        req[0] = 1'b1; addr[0] = 32'h8;
        @(negedge clk);
        n_vec++;
        if (gnt[0] !== 1'b1) begin
            n_err++; $display("FAIL rstdrop_gnt: got %b want 1", gnt[0]);
        end
        next_cycle();
        reset_n = 1'b0; req[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) reset_n = 1'b1;
            @(negedge clk);
            n_vec++;
            if ({gnt[0], ce[0], valid[0], err[0]} !== 4'b0000 || rdata[0] !== 32'h0) begin
                n_err++; $display("FAIL rstdrop_c%0d: got %b data %h want 0000 0", c, {gnt[0], ce[0], valid[0], err[0]}, rdata[0]);
            end
            next_cycle();
        end
        req[0] = 1'b1; addr[0] = 32'hC;
        next_cycle();
        req[0] = 1'b0;
        @(negedge clk);
        n_vec++;
        if (valid[0] !== 1'b1 || rdata[0] !== sram_word(32'd3)) begin
            n_err++; $display("FAIL rstdrop_regrant: got valid %b data %h want 1 %h", valid[0], rdata[0], sram_word(32'd3));
        end
        next_cycle();
    endtask

    task automatic test_random();
        int          waited    [3];
        logic        exp_pend  [3];
        logic        exp_perr  [3];
        logic [31:0] exp_pdata [3];
        logic        held      [3];
        longint      a, lo, hi;
        logic        inr, exp_gnt;
        logic [31:0] exp_r;
        idle_all();
        next_cycle();
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            waited[k] = 0; exp_pend[k] = 1'b0; exp_perr[k] = 1'b0;
            exp_pdata[k] = 32'h0; held[k] = 1'b0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                if (held[k]) begin
                    req[k] = ($urandom_range(0, 9) != 0);
                end else begin
                    req[k] = ($urandom_range(0, 99) < 75);
                    case ($urandom_range(0, 3))
                        0:       addr[k] = BASE[k] + 32'(4 * $urandom_range(0, WORDS[k] - 1)) + 32'($urandom_range(0, 3));
                        1:       addr[k] = BASE[k] - 32'($urandom_range(1, 64));
                        2:       addr[k] = BASE[k] + 32'(4 * WORDS[k]) + 32'($urandom_range(0, 64));
                        default: addr[k] = $urandom();
                    endcase
                end
                busy[k] = ($urandom_range(0, 99) < 30);
            end
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                a   = longint'(addr[k]);
                lo  = longint'(BASE[k]);
                hi  = lo + 4 * longint'(WORDS[k]);
                inr = (a >= lo) && (a < hi);
                exp_gnt = req[k] && (waited[k] >= WAITS[k]) && (!inr || !busy[k]);
                exp_r   = exp_pend[k] ? exp_pdata[k] : 32'h0;
                n_vec++;
                if ({gnt[k], ce[k], valid[k], err[k]} !== {exp_gnt, exp_gnt && inr, exp_pend[k], exp_pend[k] && exp_perr[k]}) begin
                    n_err++; $display("FAIL rand_ctl[%0d] cyc %0d: got %b want %b", k, cyc,
                        {gnt[k], ce[k], valid[k], err[k]}, {exp_gnt, exp_gnt && inr, exp_pend[k], exp_pend[k] && exp_perr[k]});
                end
                n_vec++;
                if (rdata[k] !== exp_r) begin
                    n_err++; $display("FAIL rand_data[%0d] cyc %0d: got %h want %h", k, cyc, rdata[k], exp_r);
                end
                if (exp_gnt && inr) begin
                    n_vec++;
                    if (get_maddr(k) !== 32'((a - lo) / 4)) begin
                        n_err++; $display("FAIL rand_maddr[%0d] cyc %0d: got %0d want %0d", k, cyc, get_maddr(k), (a - lo) / 4);
                    end
                end
                waited[k]    = (req[k] && !exp_gnt) ? waited[k] + 1 : 0;
                held[k]      = req[k] && !exp_gnt;
                exp_pend[k]  = exp_gnt;
                exp_perr[k]  = !inr;
                exp_pdata[k] = (exp_gnt && inr) ? sram_word(32'((a - lo) / 4)) : 32'h0;
            end
            next_cycle();
        end
        idle_all();
        next_cycle();
    endtask

    // Bound on total run time.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // Test sequence.
    initial begin
        reset_n = 1'b0;
        idle_all();
        test_reset();
        test_basic();
        test_wait();
        test_back_to_back();
        test_out_of_range();
        test_busy();
        test_reset_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_mem_bridge.md
INSTR_MEM_BRIDGE -- requirements
Module: instr_mem_bridge

Interface
REQ-001 Parameter ADDR_BASE, default 32'h0000_0000, byte base address of the instruction SRAM window.
REQ-002 Parameter MEM_WORDS, default 16384, SRAM depth in 32-bit words; power of two.
REQ-003 Parameter WAIT_CYCLES, default 0, range 0-7, minimum cycles a request is held before grant.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 instr_req  input  1  fetch request from the fetch stage.
REQ-008 instr_addr  input  32  byte address; stable while instr_req=1 and instr_gnt=0.
REQ-009 instr_gnt  output  1  request accepted this cycle.
REQ-010 instr_rdata  output  32  fetched word.
REQ-011 instr_err  output  1  bus error qualifier for instr_rdata.
REQ-012 instr_valid  output  1  response valid, one-cycle pulse.
REQ-013 mem_ce  output  1  SRAM read enable.
REQ-014 mem_addr  output  log2(MEM_WORDS)  SRAM word index.
REQ-015 mem_rdata  input  32  SRAM read data, returned the cycle after mem_ce.
REQ-016 mem_busy  input  1  arbiter denies the SRAM this cycle.

Function
REQ-017 In range: ADDR_BASE <= instr_addr < ADDR_BASE + 4*MEM_WORDS, compared in 33-bit unsigned arithmetic so the window end never wraps.
REQ-018 instr_addr[1:0] SHALL be ignored; mem_addr = (instr_addr - ADDR_BASE) >> 2, truncated to mem_addr width.
REQ-019 FSM states: IDLE (no request pending), WAIT (request held, wait_cnt counting), GRANT (grant allowed).
REQ-020 IDLE->WAIT when instr_req=1, gnt=0; IDLE stays IDLE when gnt=1 (back-to-back) or instr_req=0.
REQ-021 wait_cnt (3-bit) increments each cycle instr_req=1 and gnt=0, saturates at WAIT_CYCLES, clears on gnt or instr_req=0.
REQ-022 Grant eligible when instr_req=1 and wait_cnt == WAIT_CYCLES; with WAIT_CYCLES=0 gnt is combinational in the request cycle.
REQ-023 instr_gnt=1 when eligible and (out of range, or in range and mem_busy=0); mem_busy=1 holds gnt low, request stays pending.
REQ-024 mem_ce = instr_gnt AND in range; mem_ce never asserted for out-of-range requests.
REQ-025 instr_valid SHALL pulse exactly one cycle after each instr_gnt; exactly one response per grant, in order.
REQ-026 In-range response: instr_rdata = mem_rdata, instr_err=0.
REQ-027 Out-of-range response: instr_rdata = 32'h0, instr_err=1.
REQ-028 When instr_valid=0, instr_rdata = 32'h0 and instr_err = 0.
REQ-029 A new grant SHALL be allowed in the same cycle instr_valid is high (one outstanding plus one issuing); no further buffering.
REQ-030 instr_req dropping before grant aborts the request: wait_cnt clears, return to IDLE, no response.

Reset
REQ-031 Reset SHALL force FSM to IDLE, wait_cnt=0, pending-response and pending-error flags = 0.
REQ-032 Under reset: instr_gnt=0, instr_valid=0, instr_err=0, instr_rdata=0, mem_ce=0.
REQ-033 Reset asserted with a response pending SHALL drop it; no instr_valid after reset release without a new grant.

Verification
REQ-034 WAIT_CYCLES=0, ADDR_BASE=0: req addr 32'h10 -> gnt same cycle, mem_ce=1, mem_addr=4; next cycle instr_valid=1, rdata=mem_rdata, err=0.
REQ-035 WAIT_CYCLES=3: req held from cycle 0 -> gnt in cycle 3, valid in cycle 4; req dropped at cycle 2 -> no gnt, no valid.
REQ-036 Back-to-back: req held, addrs 0x0, 0x4, 0x8 on consecutive grants -> gnt 3 consecutive cycles, valid 3 consecutive cycles, data in order.
REQ-037 ADDR_BASE=32'h8000_0000, MEM_WORDS=16: addr 32'h8000_0040 -> gnt, mem_ce=0, next cycle valid=1, err=1, rdata=0; addr 32'h8000_003C -> err=0, mem_addr=15.
REQ-038 mem_busy=1 for 2 cycles with eligible req -> gnt=0 those cycles, gnt on first cycle mem_busy=0, single valid follows.
REQ-039 reset_n low in the cycle after gnt -> instr_valid stays 0; all outputs 0 until the next grant after release.
